mw93_eeprom_responder: RTL



---
 rtl/mw93_eeprom_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mw93_eeprom_responder.sv
// mw93_eeprom_responder: Microwire 93xx (x16) EEPROM device-side responder.
module mw93_eeprom_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int PROG_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_i,
  input  logic sk_i,
  input  logic di_i,
  output logic do_o,
  output logic do_oe,
  output logic busy_o,
  output logic wen_o
);
  localparam int CW = $clog2(DATA_W + ADDR_W);
  localparam int PW = $clog2(PROG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, OPC, ADDR, READ, WDATA, WAITCS, PROG} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] cs_sy, sk_sy, di_sy;
  logic cs_q, sk_q, cs_s, sk_s, di_s, sk_rise, cs_fall, start;
  logic [CW-1:0] cnt;
  logic [PW-1:0] prog_cnt;
  logic [1:0] opc;
  logic [ADDR_W-1:0] addr, a_next, sweep_a, mem_wa;
  logic [DATA_W-1:0] shreg, mem_wd;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic wen, busy, ready, data_ok, sweep;
  logic ones, wr_all, exec_now, mem_we;
  logic [1:0] top, addr_top;
  assign cs_s     = cs_sy[SYNC_STAGES-1];
  assign sk_s     = sk_sy[SYNC_STAGES-1];
  assign di_s     = di_sy[SYNC_STAGES-1];
  assign sk_rise  = sk_s & ~sk_q;
  assign cs_fall  = cs_q & ~cs_s;
  assign start    = sk_rise & cs_s & di_s;
  assign a_next   = {addr[ADDR_W-2:0], di_s};
  assign top      = a_next[ADDR_W-1 -: 2];
  assign addr_top = addr[ADDR_W-1 -: 2];
  assign wr_all   = opc == 2'b00;
  assign ones     = opc == 2'b11 || (wr_all && addr_top == 2'b10);
  // EWEN/EWDS never set data_ok and are not "ones" ops, so they never program
  assign exec_now = state == WAITCS && cs_fall && wen && (ones || data_ok);
  assign mem_we   = (exec_now && !wr_all) || (state == PROG && sweep);
  assign mem_wa   = state == PROG ? sweep_a : addr;
  assign mem_wd   = ones ? '1 : shreg;
  assign busy_o   = busy;
  assign wen_o    = wen;
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cs_sy    <= '0;
      sk_sy    <= '0;
      di_sy    <= '0;
      cs_q     <= 1'b0;
      sk_q     <= 1'b0;
      cnt      <= '0;
      prog_cnt <= '0;
      opc      <= '0;
      addr     <= '0;
      shreg    <= '0;
      sweep_a  <= '0;
      sweep    <= 1'b0;
      wen      <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      data_ok  <= 1'b0;
      do_o     <= 1'b0;
      do_oe    <= 1'b0;
    end else begin
      cs_sy <= {cs_sy[SYNC_STAGES-2:0], cs_i};
      sk_sy <= {sk_sy[SYNC_STAGES-2:0], sk_i};
      di_sy <= {di_sy[SYNC_STAGES-2:0], di_i};
      cs_q  <= cs_s;
      sk_q  <= sk_s;
      if (cs_fall && state != PROG) begin
        state    <= exec_now ? PROG : IDLE;
        busy     <= exec_now;
        sweep    <= exec_now && wr_all;
        sweep_a  <= '0;
        prog_cnt <= '0;
        cnt      <= '0;
        ready    <= 1'b0;
        do_oe    <= 1'b0;
        do_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            do_oe <= ready & cs_s & ~start;
            do_o  <= ready & cs_s & ~start;
            if (start) begin
              state   <= OPC;
              ready   <= 1'b0;
              cnt     <= '0;
              data_ok <= 1'b0;
            end
          end
          OPC: if (sk_rise) begin
            opc   <= {opc[0], di_s};
            cnt   <= cnt == CW'(1) ? '0 : cnt + CW'(1);
            state <= cnt == CW'(1) ? ADDR : OPC;
          end
          ADDR: if (sk_rise) begin
            addr <= a_next;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt   <= '0;
              state <= opc == 2'b10 ? READ :
                       (opc == 2'b01 || (wr_all && top == 2'b01)) ? WDATA : WAITCS;
              do_oe <= opc == 2'b10;
              do_o  <= 1'b0;
              shreg <= mem[a_next];
              wen   <= (wr_all && top == 2'b11) ? 1'b1 : (wr_all && top == 2'b00) ? 1'b0 : wen;
            end
          end
          READ: if (sk_rise) begin
            do_o  <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) begin
              cnt   <= '0;
              addr  <= addr + ADDR_W'(1);
              shreg <= mem[addr + ADDR_W'(1)];
            end
          end
          WDATA: if (sk_rise) begin
            shreg <= {shreg[DATA_W-2:0], di_s};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) begin
              cnt     <= '0;
              data_ok <= 1'b1;
              state   <= WAITCS;
            end
          end
          WAITCS: ;
          PROG: begin
            do_oe    <= cs_s;
            do_o     <= 1'b0;
            prog_cnt <= prog_cnt + PW'(1);
            sweep_a  <= sweep_a + ADDR_W'(1);
            if (&sweep_a) sweep <= 1'b0;
            if (prog_cnt == PW'(PROG_CYCLES - 1)) begin
              busy  <= 1'b0;
              ready <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
